sram_async_model: RTL and testbench

//  Clocked, parametrised behavioural model of an asynchronous SRAM with active-low cs/we/oe and a

---
 rtl/sram_async_model_if.sv | 13 +
 rtl/sram_async_model.sv | 160 ++++++++++++++++
 tb/tb_sram_async_model.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_async_model_if.sv
// Control and address lines of the asynchronous SRAM port.
// The bidirectional data bus stays a plain inout on the model.
interface sram_async_model_if #(
    parameter int ADDR_W = 21
);
    logic              cs;
    logic              we;
    logic              oe;
    logic [ADDR_W-1:0] addr;

    modport master (output cs, we, oe, addr);
    modport slave  (input  cs, we, oe, addr);
endinterface

// File: rtl/sram_async_model.sv
// Clocked behavioural model of an asynchronous SRAM with active-low cs/we/oe, configurable read
// latency, minimum write pulse width and sticky protocol-violation flags.
module sram_async_model #(
    parameter int                DATA_W         = 8,
    parameter int                ADDR_W         = 21,
    parameter int                DEPTH          = 2**ADDR_W,
    parameter int                READ_LAT       = 2,
    parameter int                WE_MIN         = 2,
    parameter logic [DATA_W-1:0] INIT_WORD      = '0,
    parameter bit                CLEAR_ON_RESET = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    sram_async_model_if.slave   bus,
    inout  wire  [DATA_W-1:0]   data,
    output logic                err_contention,
    output logic                err_short_write,
    output logic                err_addr_change,
    output logic                err_range,
    output logic [15:0]         write_count
);
    localparam int CNT_MAX = (READ_LAT > WE_MIN) ? READ_LAT : WE_MIN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAT_V   = CNT_W'(READ_LAT);
    localparam logic [CNT_W-1:0] WMIN_V  = CNT_W'(WE_MIN);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);

    typedef enum logic [1:0] {IDLE, READ_WAIT, READ_DRIVE, WRITE} state_t;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_SAT) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [15:0] count_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_V;
    endfunction

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rdata;
    logic              latch, commit;
    logic              set_cont, set_short, set_achg, set_range;

    wire wr_req   = ~bus.cs & ~bus.we;
    wire rd_req   = ~bus.cs & ~bus.oe;
    wire addr_chg = (bus.addr != addr_q);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        latch     = 1'b0;
        commit    = 1'b0;
        set_short = 1'b0;
        set_achg  = 1'b0;
        set_range = 1'b0;
        set_cont  = wr_req & ~bus.oe;
        unique case (state)
            IDLE: begin
                if (wr_req) begin
                    state_nxt = WRITE;
                    latch     = 1'b1;
                end else if (rd_req) begin
                    state_nxt = READ_WAIT;
                    latch     = 1'b1;
                end
            end
            READ_WAIT: begin
                if (!rd_req) state_nxt = IDLE;
                else if (wr_req) begin
                    state_nxt = WRITE;
                    latch     = 1'b1;
                end else if (addr_chg) latch = 1'b1;
                else if (cnt == LAT_V) state_nxt = READ_DRIVE;
                else cnt_nxt = cnt_inc(cnt);
            end
            READ_DRIVE: begin
                if (!rd_req) state_nxt = IDLE;
                else if (wr_req) begin
                    state_nxt = WRITE;
                    latch     = 1'b1;
                end else if (addr_chg) begin
                    state_nxt = READ_WAIT;
                    latch     = 1'b1;
                end
            end
            WRITE: begin
                if (wr_req) begin
                    if (addr_chg) begin
                        set_achg  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt   = cnt_inc(cnt);
                        wdata_nxt = data;
                    end
                end else begin
                    // Pulse ended: commit only if long enough and inside the array.
                    state_nxt = IDLE;
                    if (cnt >= WMIN_V) commit = in_range(addr_q);
                    else set_short = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (latch) begin
            cnt_nxt   = CNT_W'(1);
            addr_nxt  = bus.addr;
            wdata_nxt = data;
            set_range = !in_range(bus.addr);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            err_contention  <= 1'b0;
            err_short_write <= 1'b0;
            err_addr_change <= 1'b0;
            err_range       <= 1'b0;
            write_count     <= '0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            err_contention  <= err_contention  | set_cont;
            err_short_write <= err_short_write | set_short;
            err_addr_change <= err_addr_change | set_achg;
            err_range       <= err_range       | set_range;
            if (commit) write_count <= count_inc(write_count);
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_nxt;
        wdata_q <= wdata_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (CLEAR_ON_RESET) begin
                for (int i = 0; i < DEPTH; i++) mem[IDX_W'(i)] <= INIT_WORD;
            end
        end else if (commit) begin
            mem[addr_q[IDX_W-1:0]] <= wdata_q;
        end
    end

    assign rdata = in_range(addr_q) ? mem[addr_q[IDX_W-1:0]] : '0;
    assign data  = (state == READ_DRIVE) ? rdata : 'z;
endmodule

// File: tb/tb_sram_async_model.sv
// Bench for sram_async_model: two instances (default geometry, and a small clearing array with
// longer timing) checked against a shadow-memory reference model under random traffic.
module tb_sram_async_model;
    localparam int LAT0 = 2, WEM0 = 2;
    localparam int LAT1 = 3, WEM1 = 3, DEP1 = 200;
    localparam logic [7:0] INIT1 = 8'h5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, cs0, cs1, we, oe, drv;
    logic [20:0] addr;
    logic [7:0]  dq;
    wire  [7:0]  data0, data1;
    logic        ec0, es0, ea0, er0, ec1, es1, ea1, er1;
    logic [15:0] wc0, wc1;
    wire  [3:0]  fl0 = {ec0, es0, ea0, er0};
    wire  [3:0]  fl1 = {ec1, es1, ea1, er1};

    assign data0 = drv ? dq : 8'bz;
    assign data1 = drv ? dq : 8'bz;

    sram_async_model_if #(.ADDR_W(21)) if0 ();
    sram_async_model_if #(.ADDR_W(8))  if1 ();
    assign if0.cs = cs0;  assign if0.we = we;  assign if0.oe = oe;  assign if0.addr = addr;
    assign if1.cs = cs1;  assign if1.we = we;  assign if1.oe = oe;  assign if1.addr = addr[7:0];

    sram_async_model #(.DATA_W(8), .ADDR_W(21), .READ_LAT(LAT0), .WE_MIN(WEM0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave), .data(data0),
        .err_contention(ec0), .err_short_write(es0), .err_addr_change(ea0), .err_range(er0),
        .write_count(wc0));

    sram_async_model #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEP1), .READ_LAT(LAT1), .WE_MIN(WEM1),
                       .INIT_WORD(INIT1), .CLEAR_ON_RESET(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave), .data(data1),
        .err_contention(ec1), .err_short_write(es1), .err_addr_change(ea1), .err_range(er1),
        .write_count(wc1));

    // Reference model: shadow memories, expected flags {contention, short, addr_change, range}.
    logic [7:0] rm0 [int];
    logic [7:0] rm1 [0:DEP1-1];
    logic [3:0] xfl [2];
    int         xwc [2];
    int         nvec = 0, nfail = 0;

    function automatic int lat_of(int w); return w ? LAT1 : LAT0; endfunction
    function automatic int wem_of(int w); return w ? WEM1 : WEM0; endfunction
    function automatic logic [7:0] bus_val(int w); return w ? data1 : data0; endfunction
    function automatic bit released(logic [7:0] v); return $isunknown(v) || v == 8'h00; endfunction
    function automatic logic [7:0] exp_rd(int w, int a);
        if (w == 0) return rm0[a];
        return (a < DEP1) ? rm1[a] : 8'h00;
    endfunction

    task automatic cyc(int n); repeat (n) begin @(posedge clk); #1; end endtask
    task automatic idle(); cs0 = 1; cs1 = 1; we = 1; oe = 1; drv = 0; endtask
    task automatic sel(int w); if (w != 0) cs1 = 0; else cs0 = 0; endtask

    task automatic model_reset();
        xfl[0] = '0; xfl[1] = '0; xwc[0] = 0; xwc[1] = 0;
        for (int i = 0; i < DEP1; i++) rm1[i] = INIT1;
    endtask

    task automatic model_write(int w, int a, logic [7:0] d, int nlow);
        if (w == 1 && a >= DEP1) xfl[1][0] = 1'b1;
        if (nlow < wem_of(w)) xfl[w][2] = 1'b1;
        else if (w == 0 || a < DEP1) begin
            if (w == 0) rm0[a] = d; else rm1[a] = d;
            xwc[w] = (xwc[w] == 65535) ? 65535 : xwc[w] + 1;
        end
    endtask

    task automatic wr(int w, int a, logic [7:0] d, int nlow);
        idle(); sel(w); we = 0; addr = 21'(a); dq = d; drv = 1;
        cyc(nlow);
        idle(); cyc(1);
        model_write(w, a, d, nlow);
    endtask

    task automatic rd(int w, int a, output bit rel_ok, output logic [7:0] v);
        idle(); sel(w); oe = 0; addr = 21'(a); rel_ok = 1;
        for (int i = 0; i < lat_of(w); i++) begin
            cyc(1);
            if (!released(bus_val(w))) rel_ok = 0;
        end
        cyc(1); v = bus_val(w);
        idle(); cyc(1);
        if (!released(bus_val(w))) rel_ok = 0;
        if (w == 1 && a >= DEP1) xfl[1][0] = 1'b1;
    endtask

    task automatic test_reset();
        idle(); addr = '0; dq = '0; reset = 1; cyc(2); reset = 0; cyc(1);
        model_reset();
        nvec++; if (fl0 !== xfl[0]) begin nfail++; $display("FAIL reset_flags0 got %b want %b", fl0, xfl[0]); end
        nvec++; if (wc0 !== 16'(xwc[0])) begin nfail++; $display("FAIL reset_wc0 got %0d want %0d", wc0, xwc[0]); end
        nvec++; if (fl1 !== xfl[1]) begin nfail++; $display("FAIL reset_flags1 got %b want %b", fl1, xfl[1]); end
        nvec++; if (wc1 !== 16'(xwc[1])) begin nfail++; $display("FAIL reset_wc1 got %0d want %0d", wc1, xwc[1]); end
        nvec++; if (!released(data0) || !released(data1)) begin nfail++; $display("FAIL reset_bus got %h/%h want Z", data0, data1); end
    endtask

    task automatic test_read_latency();
        logic [7:0] d;
        d = 8'($urandom_range(1, 255));
        wr(0, 5, d, 2);
        idle(); cs0 = 0; oe = 0; addr = 21'd5;
        for (int e = 0; e < LAT0; e++) begin
            cyc(1);
            nvec++; if (!released(data0)) begin nfail++; $display("FAIL lat_hiz edge%0d got %h want Z", e, data0); end
        end
        cyc(1);
        nvec++; if (data0 !== d) begin nfail++; $display("FAIL lat_data got %h want %h", data0, d); end
        idle(); cyc(1);
        nvec++; if (!released(data0)) begin nfail++; $display("FAIL lat_release got %h want Z", data0); end
    endtask

    task automatic test_write_readback();
        bit ok; logic [7:0] v; int q[$]; int a;
        wr(0, 21'h1F0000, 8'hA5, 2);
        nvec++; if (wc0 !== 16'(xwc[0])) begin nfail++; $display("FAIL wr_count got %0d want %0d", wc0, xwc[0]); end
        rd(0, 21'h1F0000, ok, v);
        nvec++; if (!ok || v !== 8'hA5) begin nfail++; $display("FAIL wr_readback got %h ok=%0d want A5", v, ok); end
        for (int i = 0; i < 16; i++) begin
            a = int'($urandom_range(0, 21'h1FFFFF));
            q.push_back(a);
            wr(0, a, 8'($urandom_range(1, 255)), int'($urandom_range(WEM0, WEM0 + 2)));
        end
        foreach (q[i]) begin
            rd(0, q[i], ok, v);
            nvec++; if (!ok || v !== exp_rd(0, q[i])) begin nfail++; $display("FAIL rand_rd0 addr %h got %h ok=%0d want %h", q[i], v, ok, exp_rd(0, q[i])); end
        end
        nvec++; if (fl0 !== xfl[0] || wc0 !== 16'(xwc[0])) begin nfail++; $display("FAIL rand_state0 got %b/%0d want %b/%0d", fl0, wc0, xfl[0], xwc[0]); end
    endtask

    task automatic test_short_write();
        bit ok; logic [7:0] v;
        wr(0, 21'h1F0000, 8'h3C, 1);
        nvec++; if (fl0 !== xfl[0]) begin nfail++; $display("FAIL short_flags got %b want %b", fl0, xfl[0]); end
        nvec++; if (wc0 !== 16'(xwc[0])) begin nfail++; $display("FAIL short_count got %0d want %0d", wc0, xwc[0]); end
        rd(0, 21'h1F0000, ok, v);
        nvec++; if (v !== rm0[21'h1F0000]) begin nfail++; $display("FAIL short_word got %h want %h", v, rm0[21'h1F0000]); end
    endtask

    task automatic test_read_addr_change();
        logic [7:0] d;
        d = 8'($urandom_range(1, 254));
        wr(0, 3, d, 2); wr(0, 4, d + 8'd1, 2);
        idle(); cs0 = 0; oe = 0; addr = 21'd3;
        cyc(1);
        addr = 21'd4;
        for (int e = 0; e < LAT0; e++) begin
            cyc(1);
            nvec++; if (!released(data0)) begin nfail++; $display("FAIL rachg_hiz step%0d got %h want Z", e, data0); end
        end
        cyc(1);
        nvec++; if (data0 !== rm0[4]) begin nfail++; $display("FAIL rachg_data got %h want %h", data0, rm0[4]); end
        idle(); cyc(1);
    endtask

    task automatic test_back_to_back();
        idle(); cs0 = 0; oe = 0; addr = 21'd4;
        cyc(LAT0 + 1);
        nvec++; if (data0 !== rm0[4]) begin nfail++; $display("FAIL b2b_first got %h want %h", data0, rm0[4]); end
        addr = 21'd3;
        for (int e = 0; e < LAT0; e++) begin
            cyc(1);
            nvec++; if (!released(data0)) begin nfail++; $display("FAIL b2b_hiz step%0d got %h want Z", e, data0); end
        end
        cyc(1);
        nvec++; if (data0 !== rm0[3]) begin nfail++; $display("FAIL b2b_second got %h want %h", data0, rm0[3]); end
        idle(); cyc(1);
    endtask

    task automatic test_contention();
        bit ok; logic [7:0] v; int a;
        a = int'($urandom_range(16, 21'h0FFFFF));
        idle(); cs0 = 0; we = 0; oe = 0; addr = 21'(a); dq = 8'h77; drv = 1;
        for (int e = 0; e < 2; e++) begin
            cyc(1);
            nvec++; if (data0 !== 8'h77) begin nfail++; $display("FAIL cont_bus edge%0d got %h want 77", e, data0); end
        end
        idle(); cyc(1);
        model_write(0, a, 8'h77, 2); xfl[0][3] = 1'b1;
        nvec++; if (fl0 !== xfl[0] || wc0 !== 16'(xwc[0])) begin nfail++; $display("FAIL cont_state got %b/%0d want %b/%0d", fl0, wc0, xfl[0], xwc[0]); end
        rd(0, a, ok, v);
        nvec++; if (!ok || v !== 8'h77) begin nfail++; $display("FAIL cont_readback got %h ok=%0d want 77", v, ok); end
    endtask

    task automatic test_addr_change_write();
        bit ok; logic [7:0] v;
        idle(); cs0 = 0; we = 0; addr = 21'd3; dq = ~rm0[3]; drv = 1;
        cyc(1);
        addr = 21'd4;
        cyc(1);
        idle(); cyc(1);
        xfl[0][1] = 1'b1;
        nvec++; if (fl0 !== xfl[0] || wc0 !== 16'(xwc[0])) begin nfail++; $display("FAIL wachg_state got %b/%0d want %b/%0d", fl0, wc0, xfl[0], xwc[0]); end
        rd(0, 3, ok, v);
        nvec++; if (v !== rm0[3]) begin nfail++; $display("FAIL wachg_word3 got %h want %h", v, rm0[3]); end
        rd(0, 4, ok, v);
        nvec++; if (v !== rm0[4]) begin nfail++; $display("FAIL wachg_word4 got %h want %h", v, rm0[4]); end
    endtask

    task automatic test_range();
        bit ok; logic [7:0] v;
        wr(1, 250, 8'h99, WEM1);
        nvec++; if (fl1 !== xfl[1] || wc1 !== 16'(xwc[1])) begin nfail++; $display("FAIL range_wr got %b/%0d want %b/%0d", fl1, wc1, xfl[1], xwc[1]); end
        rd(1, 210, ok, v);
        nvec++; if (v !== 8'h00) begin nfail++; $display("FAIL range_rd got %h want 00", v); end
        wr(1, DEP1 - 1, 8'hC3, WEM1);
        rd(1, DEP1 - 1, ok, v);
        nvec++; if (!ok || v !== 8'hC3) begin nfail++; $display("FAIL range_top got %h ok=%0d want C3", v, ok); end
    endtask

    task automatic test_dut1_random();
        bit ok; logic [7:0] v; int a;
        for (int i = 0; i < 20; i++) begin
            wr(1, int'($urandom_range(0, DEP1 - 1)), 8'($urandom_range(1, 255)), int'($urandom_range(1, WEM1 + 1)));
            a = int'($urandom_range(0, DEP1 - 1));
            rd(1, a, ok, v);
            nvec++; if (!ok || v !== exp_rd(1, a)) begin nfail++; $display("FAIL rand_rd1 addr %0d got %h ok=%0d want %h", a, v, ok, exp_rd(1, a)); end
        end
        nvec++; if (fl1 !== xfl[1] || wc1 !== 16'(xwc[1])) begin nfail++; $display("FAIL rand_state1 got %b/%0d want %b/%0d", fl1, wc1, xfl[1], xwc[1]); end
    endtask

    task automatic test_reset_mid_write();
        bit ok; logic [7:0] v;
        wr(0, 7, 8'h11, WEM0); wr(1, 7, 8'h11, WEM1); wr(1, 9, 8'h4B, WEM1);
        idle(); cs0 = 0; cs1 = 0; we = 0; addr = 21'd7; dq = 8'h22; drv = 1;
        cyc(1);
        reset = 1; cyc(1);
        reset = 0; idle(); cyc(1);
        model_reset();
        nvec++; if (fl0 !== xfl[0] || wc0 !== 16'(xwc[0])) begin nfail++; $display("FAIL rstmid_state0 got %b/%0d want %b/%0d", fl0, wc0, xfl[0], xwc[0]); end
        nvec++; if (fl1 !== xfl[1] || wc1 !== 16'(xwc[1])) begin nfail++; $display("FAIL rstmid_state1 got %b/%0d want %b/%0d", fl1, wc1, xfl[1], xwc[1]); end
        rd(0, 7, ok, v);
        nvec++; if (!ok || v !== rm0[7]) begin nfail++; $display("FAIL rstmid_keep got %h ok=%0d want %h", v, ok, rm0[7]); end
        rd(1, 7, ok, v);
        nvec++; if (!ok || v !== rm1[7]) begin nfail++; $display("FAIL rstmid_clear7 got %h ok=%0d want %h", v, ok, rm1[7]); end
        rd(1, 9, ok, v);
        nvec++; if (!ok || v !== rm1[9]) begin nfail++; $display("FAIL rstmid_clear9 got %h ok=%0d want %h", v, ok, rm1[9]); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle(); reset = 1; addr = '0; dq = '0;
        test_reset();
        test_read_latency();
        test_write_readback();
        test_short_write();
        test_read_addr_change();
        test_back_to_back();
        test_contention();
        test_addr_change_write();
        test_range();
        test_dut1_random();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
